gc_tx_serializer: RTL and testbench

Downstream of the garbling engine: captures every non-idle record from its `tag`/`index`/`data` output stream into a record FIFO and serializes each record into 64-bit beats on a valid/ready link to the host transport. The garbler has no backpressure, so this block absorbs bursts, drops and flags records on overflow, and collapses the garbler's continuously repeated mask record into a single transfer.

---
 rtl/gc_tx_serializer.sv | 168 ++++++++++++++++
 tb/tb_gc_tx_serializer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gc_tx_serializer.sv
// Record FIFO and 64-bit beat serializer between the garbling engine and the host link.
// Records are captured without backpressure; overflowing records are dropped and counted.
module gc_tx_serializer #(
    parameter int unsigned S = 20,
    parameter int unsigned K = 128,
    parameter int unsigned D = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   tag,
    input  logic [S-1:0] index0,
    input  logic [S-1:0] index1,
    input  logic [K-1:0] data0,
    input  logic [K-1:0] data1,
    output logic [63:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         overflow,
    output logic [15:0]  drop_cnt
);

    localparam int unsigned Beats = K / 64;
    localparam int unsigned BcW   = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int unsigned PtrW  = (D > 1) ? $clog2(D) : 1;
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned EntW  = 3 + 2 * S + 2 * K;

    typedef enum logic [1:0] {StIdle, StHdr, StD0, StD1} state_e;

    state_e          state_q, state_d;
    logic [BcW-1:0]  bc_q, bc_d;
    logic            out_valid_q, out_valid_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      prev_tag_q, prev_tag_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;
    logic [EntW-1:0] mem_q [D];

    logic            offered, full, wr_en, drop, hs, pop, two_part, last_bc;
    logic [EntW-1:0] head;
    logic [2:0]      h_tag;
    logic [S-1:0]    h_idx0, h_idx1;
    logic [K-1:0]    h_data0, h_data1;
    logic [BcW+5:0]  off;
    logic [63:0]     hdr;

    assign head    = mem_q[rd_ptr_q];
    assign h_tag   = head[EntW-1 -: 3];
    assign h_idx0  = head[2*K+2*S-1 -: S];
    assign h_idx1  = head[2*K+S-1 -: S];
    assign h_data0 = head[2*K-1 -: K];
    assign h_data1 = head[K-1:0];

    assign two_part = h_tag inside {3'b001, 3'b010, 3'b011, 3'b111};
    assign last_bc  = (bc_q == BcW'(Beats - 1));
    assign off      = {bc_q, 6'd0};

    // A held mask tag is a repeat of the same record; only its first cycle counts.
    assign offered = (tag != 3'b000) && !((tag == 3'b011) && (prev_tag_q == 3'b011));
    assign full    = (cnt_q == CntW'(D));
    assign wr_en   = offered && !full;
    assign drop    = offered && full;
    assign hs      = out_valid_q && out_ready;

    always_comb begin
        hdr        = '0;
        hdr[63:61] = h_tag;
        hdr[60:56] = two_part ? 5'(2 * Beats) : 5'(Beats);
        hdr[2*S-1:S] = h_idx1;
        hdr[S-1:0]   = h_idx0;
    end

    always_comb begin
        out_data = '0;
        case (state_q)
            StHdr:   out_data = hdr;
            StD0:    out_data = h_data0[off +: 64];
            StD1:    out_data = h_data1[off +: 64];
            default: out_data = '0;
        endcase
    end

    assign out_last  = last_bc && ((state_q == StD1) || ((state_q == StD0) && !two_part));
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

    always_comb begin
        state_d = state_q;
        bc_d    = bc_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: if (cnt_q != '0) state_d = StHdr;
            StHdr: begin
                if (hs) begin
                    bc_d    = '0;
                    state_d = (h_tag == 3'b110) ? StD1 : StD0;
                end
            end
            StD0: begin
                if (hs) begin
                    if (!last_bc) begin
                        bc_d = bc_q + BcW'(1);
                    end else if (two_part) begin
                        bc_d    = '0;
                        state_d = StD1;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            StD1: begin
                if (hs) begin
                    if (!last_bc) bc_d = bc_q + BcW'(1);
                    else          pop  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        // A same-cycle write counts as a remaining record, so records chain back to back.
        if (pop) begin
            bc_d    = '0;
            state_d = ((cnt_q > CntW'(1)) || wr_en) ? StHdr : StIdle;
        end
        out_valid_d = (state_d != StIdle);
    end

    always_comb begin
        wr_ptr_d   = wr_en ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        cnt_d      = cnt_q + CntW'(wr_en) - CntW'(pop);
        prev_tag_d = tag;
        overflow_d = overflow_q | drop;
        drop_cnt_d = (drop && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            bc_q        <= '0;
            out_valid_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            prev_tag_q  <= 3'b000;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            bc_q        <= bc_d;
            out_valid_q <= out_valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            prev_tag_q  <= prev_tag_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {tag, index0, index1, data0, data1};
    end

endmodule

// File: tb/tb_gc_tx_serializer.sv
// Randomized and directed bench for gc_tx_serializer against a record-level beat scoreboard.
module tb_gc_tx_serializer;

    localparam int unsigned S = 20;
    localparam int unsigned K = 128;
    localparam int unsigned D = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   tag;
    logic [S-1:0] index0, index1;
    logic [K-1:0] data0, data1;
    logic [63:0]  out_data;
    logic         out_valid, out_ready, out_last, overflow;
    logic [15:0]  drop_cnt;

    always #5 clk = ~clk;

    gc_tx_serializer #(.S(S), .K(K), .D(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .tag       (tag),
        .index0    (index0),
        .index1    (index1),
        .data0     (data0),
        .data1     (data1),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    typedef struct packed {
        logic        last;
        logic [63:0] data;
    } beat_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    beat_t       sb[$];
    int          m_occ;
    int          m_drops;
    logic        m_ovf;
    logic [2:0]  m_prev;
    logic        prev_stall;
    logic [64:0] prev_beat;
    int          rdy_mode = 0;
    int          phase    = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Expected beat stream of one record, built from the tag's beat rules.
    task automatic push_rec(input logic [2:0] t, input logic [S-1:0] i0, input logic [S-1:0] i1,
                            input logic [K-1:0] d0, input logic [K-1:0] d1);
        logic [63:0] words[$];
        logic [63:0] h;
        bit          has0, has1;
        has0 = (t != 3'b110);
        has1 = (t inside {3'b001, 3'b010, 3'b011, 3'b111, 3'b110});
        h = '0;
        h[63:61] = t;
        h[60:56] = 5'((int'(has0) + int'(has1)) * (K / 64));
        h[2*S-1 -: S] = i1;
        h[S-1:0] = i0;
        words.push_back(h);
        if (has0) for (int b = 0; b < K / 64; b++) words.push_back(d0[64*b +: 64]);
        if (has1) for (int b = 0; b < K / 64; b++) words.push_back(d1[64*b +: 64]);
        for (int w = 0; w < words.size(); w++) sb.push_back({(w == words.size() - 1), words[w]});
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            m_occ = 0; m_drops = 0; m_ovf = 1'b0; m_prev = 3'b000; prev_stall = 1'b0;
        end else begin
            bit full;
            beat_t e;
            if (prev_stall) begin
                check("stall_valid", {63'b0, out_valid}, 64'd1);
                check("stall_data", out_data, prev_beat[63:0]);
                check("stall_last", {63'b0, out_last}, {63'b0, prev_beat[64]});
            end
            check("overflow", {63'b0, overflow}, {63'b0, m_ovf});
            check("drop_cnt", {48'b0, drop_cnt}, 64'(m_drops));
            full = (m_occ == D);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", {63'b0, out_valid}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("beat_data", out_data, e.data);
                    check("beat_last", {63'b0, out_last}, {63'b0, e.last});
                    if (e.last) m_occ--;
                end
            end
            if (tag != 3'b000 && !(tag == 3'b011 && m_prev == 3'b011)) begin
                if (full) begin
                    m_ovf = 1'b1;
                    if (m_drops < 16'hFFFF) m_drops++;
                end else begin
                    push_rec(tag, index0, index1, data0, data1);
                    m_occ++;
                end
            end
            m_prev     = tag;
            prev_stall = out_valid && !out_ready;
            prev_beat  = {out_last, out_data};
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = (phase % 3 == 0);
                default: out_ready = 1'b0;
            endcase
            phase++;
        end
    end

    task automatic drive(input logic [2:0] t, input logic [S-1:0] i0, input logic [S-1:0] i1,
                         input logic [K-1:0] d0, input logic [K-1:0] d1);
        @(posedge clk);
        #1;
        tag = t; index0 = i0; index1 = i1; data0 = d0; data1 = d1;
    endtask

    task automatic idle();
        drive(3'b000, '0, '0, '0, '0);
    endtask

    function automatic logic [K-1:0] rnd_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0 && !out_valid) break;
        end
        check("drain_queue", 64'(sb.size()), 64'd0);
        check("drain_valid", {63'b0, out_valid}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] tags [6];
        tags = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
        rst = 1'b0; tag = '0; index0 = '0; index1 = '0; data0 = '0; data1 = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", {63'b0, out_valid}, 64'd0);
        check("rst_last", {63'b0, out_last}, 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_ovf", {63'b0, overflow}, 64'd0);
        check("rst_drop", {48'b0, drop_cnt}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Single 111 record: header two cycles after the offer.
        drive(3'b111, S'(5), S'(6), K'(1), K'(2));
        @(negedge clk);
        check("lat_t0", {63'b0, out_valid}, 64'd0);
        idle();
        @(negedge clk);
        check("lat_t1", {63'b0, out_valid}, 64'd0);
        @(negedge clk);
        check("lat_t2", {63'b0, out_valid}, 64'd1);
        check("hdr_111", out_data, 64'hE400_0000_0060_0005);
        wait_drain(50);

        drive(3'b110, S'(3), S'(9), rnd_data(), {64'hA, 64'hB});
        drive(3'b101, S'(7), S'(1), rnd_data(), rnd_data());
        idle();
        wait_drain(50);

        // Held mask tag collapses to one record until the tag drops.
        for (int i = 0; i < 50; i++) drive(3'b011, '1, '1, K'(128'h55), K'(128'hAA));
        idle();
        for (int i = 0; i < 5; i++) drive(3'b011, '1, '1, K'(128'h66), K'(128'hBB));
        idle();
        wait_drain(100);

        rdy_mode = 2;
        drive(3'b111, S'($urandom), S'($urandom), rnd_data(), rnd_data());
        drive(3'b101, S'($urandom), S'($urandom), rnd_data(), rnd_data());
        drive(3'b010, S'($urandom), S'($urandom), rnd_data(), rnd_data());
        idle();
        wait_drain(200);

        rdy_mode = 3;
        idle();
        for (int i = 0; i < 20; i++) drive(3'b010, S'(i), S'($urandom), rnd_data(), rnd_data());
        idle();
        @(negedge clk);
        check("ovf_flag", {63'b0, overflow}, 64'd1);
        check("ovf_drops", {48'b0, drop_cnt}, 64'd4);
        rdy_mode = 0;
        wait_drain(500);

        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 0) idle();
            else drive(tags[$urandom_range(0, 5)], S'($urandom), S'($urandom),
                       rnd_data(), rnd_data());
        end
        idle();
        wait_drain(3000);

        // Reset while D0 beat 1 is on the link.
        rdy_mode = 0;
        drive(3'b111, S'(11), S'(12), rnd_data(), rnd_data());
        idle();
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        check("mid_hdr_seen", {63'b0, out_valid}, 64'd1);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_valid", {63'b0, out_valid}, 64'd0);
        check("mid_rst_data", out_data, 64'd0);
        check("mid_rst_drop", {48'b0, drop_cnt}, 64'd0);
        check("mid_rst_ovf", {63'b0, overflow}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        drive(3'b101, S'(21), S'(22), rnd_data(), rnd_data());
        idle();
        wait_drain(50);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
